// File: rtl/regfile_mp_sb.sv
// Multi-port byte-maskable integer register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp_sb #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int BW      = XLEN / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic [NUM_WR*BW-1:0]     wr_be,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic                     rsv_ok,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [XLEN-1:0]     mem_q [NUM_REGS];
  logic [XLEN-1:0]     mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // busy_q[0] is never set when ZERO_REG=1, so x0 reservations are always accepted.
  assign rsv_ok   = rsv_en & ~busy_q[rsv_addr];
  assign busy_vec = busy_q;

  // Ports are applied in index order so the highest-index port owns each contested byte.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && !is_zero(wr_addr[p*AW +: AW])) begin
        for (int b = 0; b < BW; b++) begin
          if (wr_be[p*BW+b])
            mem_d[wr_addr[p*AW +: AW]][b*8 +: 8] = wr_data[p*XLEN + b*8 +: 8];
        end
        busy_d[wr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    // Writeback clears first, then an accepted reservation re-arms the bit.
    if (rsv_ok && !is_zero(rsv_addr))
      busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
      rd_busy[k]              = busy_q[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr[k*AW +: AW])) begin
          for (int b = 0; b < BW; b++) begin
            if (wr_be[p*BW+b])
              rd_data[k*XLEN + b*8 +: 8] = wr_data[p*XLEN + b*8 +: 8];
          end
          rd_busy[k] = 1'b0;
        end
      end
`endif
      if (is_zero(rd_addr[k*AW +: AW])) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_busy[k]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed vector table plus randomized traffic
// checked against an array-based reference model.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;
  logic [31:0] busy_vec;

  regfile_mp_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;
  logic last_ok;

  // Reference state: one word and one busy flag per architectural register.
  logic [31:0] mdl_mem [32];
  logic [31:0] mdl_busy;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [3:0]  be0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [3:0]  be1;
    logic        rsv;
    logic [4:0]  ra;
    logic        exp_ok;
    logic [4:0]  chk;
    logic [31:0] exp_word;
    logic        exp_busy;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [4:0] a);
    logic [31:0] w;
    if (a == 5'd0) return 32'h0;
    w = mdl_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p*5 +: 5] == a)
        for (int b = 0; b < 4; b++)
          if (wr_be[p*4+b]) w[b*8 +: 8] = wr_data[p*32 + b*8 +: 8];
`endif
    return w;
  endfunction

  function automatic logic mdl_rb(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p*5 +: 5] == a) return 1'b0;
`endif
    return mdl_busy[a];
  endfunction

  function automatic logic mdl_ok();
    return rsv_en && (rsv_addr == 5'd0 || !mdl_busy[rsv_addr]);
  endfunction

  function automatic void mdl_edge();
    logic ok;
    logic [4:0] a;
    ok = mdl_ok();
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_mem[i] = 32'h0;
      mdl_busy = 32'h0;
      return;
    end
    for (int p = 0; p < 2; p++) begin
      a = wr_addr[p*5 +: 5];
      if (wr_en[p] && a != 5'd0) begin
        for (int b = 0; b < 4; b++)
          if (wr_be[p*4+b]) mdl_mem[a][b*8 +: 8] = wr_data[p*32 + b*8 +: 8];
        mdl_busy[a] = 1'b0;
      end
    end
    if (ok && rsv_addr != 5'd0) mdl_busy[rsv_addr] = 1'b1;
  endfunction

  task automatic idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
  endtask

  // Inputs are already applied; check combinational outputs at the falling edge, then clock.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("rd_data", rd_data[k*32 +: 32], mdl_rd(rd_addr[k*5 +: 5]));
        chk("rd_busy", 32'(rd_busy[k]), 32'(mdl_rb(rd_addr[k*5 +: 5])));
      end
      chk("rsv_ok", 32'(rsv_ok), 32'(mdl_ok()));
      chk("busy_vec", busy_vec, mdl_busy);
    end
    last_ok = rsv_ok;
    mdl_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    idle();
    wr_en = v.we;
    wr_addr = {v.a1, v.a0};
    wr_data = {v.d1, v.d0};
    wr_be = {v.be1, v.be0};
    rsv_en = v.rsv;
    rsv_addr = v.ra;
    rd_addr = {v.chk, v.chk};
    tick();
    chk("vec_rsv_ok", 32'(last_ok), 32'(v.exp_ok));
    idle();
    rd_addr = {5'd0, v.chk};
    #1;
    chk("vec_word", rd_data[31:0], v.exp_word);
    chk("vec_busy", 32'(busy_vec[v.chk]), 32'(v.exp_busy));
  endtask

  initial begin
    //           we     a0     d0            be0    a1     d1            be1    rsv   ra     ok    chk    word          busy
    tbl[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 4'hF, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{2'b10, 5'd0, 32'h0,        4'h0, 5'd5, 32'h000000AA, 4'h1, 1'b0, 5'd0, 1'b0, 5'd5, 32'hDEADBEAA, 1'b0};
    tbl[2] = '{2'b11, 5'd7, 32'h11111111, 4'hF, 5'd7, 32'h22222222, 4'h3, 1'b0, 5'd0, 1'b0, 5'd7, 32'h11112222, 1'b0};
    tbl[3] = '{2'b00, 5'd0, 32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd3, 1'b1, 5'd3, 32'h0,        1'b1};
    tbl[4] = '{2'b00, 5'd0, 32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd3, 1'b0, 5'd3, 32'h0,        1'b1};
    tbl[5] = '{2'b01, 5'd3, 32'hFFFFFFFF, 4'h0, 5'd0, 32'h0,        4'h0, 1'b0, 5'd0, 1'b0, 5'd3, 32'h0,        1'b0};
    tbl[6] = '{2'b01, 5'd3, 32'h00000055, 4'hF, 5'd0, 32'h0,        4'h0, 1'b1, 5'd3, 1'b1, 5'd3, 32'h00000055, 1'b1};
    tbl[7] = '{2'b01, 5'd3, 32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 1'b1, 5'd3, 1'b0, 5'd3, 32'h00000055, 1'b0};
    tbl[8] = '{2'b01, 5'd0, 32'h00001234, 4'hF, 5'd0, 32'h0,        4'h0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0,        1'b0};

    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    mdl_edge();
    chk_en = 1'b1;

    // Preload every register with ones and reserve a few, then reset with traffic pending.
    for (int i = 0; i < 16; i++) begin
      idle();
      wr_en = 2'b11;
      wr_addr = {5'(2*i+1), 5'(2*i)};
      wr_data = {2{32'hFFFFFFFF}};
      wr_be = 8'hFF;
      tick();
    end
    for (int i = 1; i < 6; i++) begin
      idle(); rsv_en = 1'b1; rsv_addr = 5'(i); rd_addr = {5'(i), 5'(i)};
      tick();
    end
    idle();
    rst = 1'b1; wr_en = 2'b01; wr_addr = 10'd9; wr_data = 64'h1234; wr_be = 8'h0F;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    tick();
    idle();
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31-i), 5'(i)};
      #1;
      chk("reset_rd0", rd_data[31:0], 32'h0);
      chk("reset_rd1", rd_data[63:32], 32'h0);
      chk("reset_busy", 32'(rd_busy), 32'h0);
    end
    chk("reset_busy_vec", busy_vec, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) apply_vec(tbl[i]);

    // Write x9 while reading it in the same cycle.
    idle();
    wr_en = 2'b01; wr_addr = 10'd9; wr_data = 64'hCAFEF00D; wr_be = 8'h0F;
    rd_addr = {5'd9, 5'd9};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_read", rd_data[31:0], 32'hCAFEF00D);
`else
    chk("same_cycle_read", rd_data[31:0], 32'h0);
`endif
    tick();
    idle();
    rd_addr = {5'd0, 5'd9};
    #1;
    chk("next_cycle_read", rd_data[31:0], 32'hCAFEF00D);

    // Randomized traffic concentrated on a few registers to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 49) == 0);
      wr_en = 2'($urandom);
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {$urandom, $urandom};
      wr_be = 8'($urandom);
      rsv_en = 1'($urandom);
      rsv_addr = 5'($urandom_range(0, 7));
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with per-register busy scoreboard, for the next pipelined RISC-V core.
- Provides NUM_RD combinational read ports and NUM_WR byte-maskable write ports.
- Holds a reservation bit per register: the issue stage sets it and writeback clears it.
- Register 0 is optionally hardwired to zero.

Parameters:
- NUM_REGS, 32, number of architectural registers (power of 2).
- XLEN, 32, register width in bits (multiple of 8).
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes/reservations; 0 = ordinary register.

Derived: AW = $clog2(NUM_REGS), BW = XLEN/8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k occupies slice k.
- rd_data  out  NUM_RD*XLEN  packed read data, combinational.
- rd_busy  out  NUM_RD  busy bit of each read address, combinational.
- wr_en  in  NUM_WR  write-port valid.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*XLEN  write data.
- wr_be  in  NUM_WR*BW  byte enables; bit b covers bits [8b+7:8b].
- rsv_en  in  1  reservation request from issue.
- rsv_addr  in  AW  register to reserve.
- rsv_ok  out  1  combinational; 1 when the request is accepted this cycle.
- busy_vec  out  NUM_REGS  registered busy bits, for debug and stall logic.

Behaviour:
Reset
- rst sampled high: all registers go to 0 and all busy bits to 0.
- Reset overrides any write or reservation in the same cycle.
- After reset: rd_data = 0, rd_busy = 0, busy_vec = 0.
- rsv_ok follows the rules below even while rst is high, but has no effect during reset.

Write
- On a rising edge with wr_en[p]=1, each byte b of mem[wr_addr[p]] with wr_be[p][b]=1 takes wr_data[p] byte b. Other bytes hold.
- Write latency: 1 cycle.
- Same address on several ports in one cycle: the resolution is per byte. The highest-index port whose byte enable is set wins that byte.
- wr_en=1 with wr_be=0: no data change, but the busy bit is still cleared.

Scoreboard
- A write on any port clears busy[wr_addr].
- rsv_ok = rsv_en & ~busy[rsv_addr].
- Accepted reservation: busy[rsv_addr] is set at the edge.
- Rejected reservation (register already busy): no state change.
- Reservation and write to the same register in the same cycle: the write's clear is applied first, then the set. Net result: busy = 1.
- The rsv_ok check uses the pre-edge busy value. A reservation to a register being written back in the same cycle, while still busy, is therefore rejected.

Read
- rd_data[k] = mem[rd_addr[k]]; rd_busy[k] = busy[rd_addr[k]]. Both are pure combinational from registered state.
- All read ports are independent, and any number may alias.

ZERO_REG=1
- Address 0 always reads 0 with rd_busy = 0.
- Writes to address 0 are dropped.
- rsv_en to address 0 gives rsv_ok = 1 with no state change.

Widths
- Addresses ≥ NUM_REGS cannot occur (power-of-2 depth).
- No arithmetic on data.

Optional Feature:
Macro: REGFILE_BYPASS_EN

Defined:
- Read ports forward same-cycle writes.
- rd_data[k] is the stored word with each byte replaced by the winning write byte from this cycle's enabled writes to rd_addr[k]. Winner selection uses the same highest-index-port-wins rule.
- rd_busy[k] is forced to 0 when any enabled write targets rd_addr[k] this cycle.
- The zero register is still forced to 0.

Undefined:
- rd_data and rd_busy reflect only registered state. A write becomes visible the cycle after the edge.

Test Plan:
1. Reset with all registers preloaded to 0xFFFFFFFF, rst=1 for one edge → every rd_data = 0, busy_vec = 0.
2. Port0 writes 0xDEADBEEF to x5 with be=4'b1111, then port1 writes 0x000000AA to x5 with be=4'b0001 → x5 reads 0xDEADBEAA one cycle later.
3. Same cycle: port0 writes 0x11111111 and port1 writes 0x22222222 to x7, be 4'b1111 and 4'b0011 → x7 = 0x11112222.
4. rsv x3 → rsv_ok=1, busy[3]=1. Next rsv x3 → rsv_ok=0. Write x3 with be=0 → busy[3]=0, data unchanged. Reservation and write to x3 in the same cycle → busy[3]=1.
5. ZERO_REG=1: write 0x1234 to x0, rsv x0 → rd_data for x0 = 0, rsv_ok=1, busy[0]=0.
6. Write 0xCAFEF00D to x9 while reading x9 in the same cycle → with REGFILE_BYPASS_EN: 0xCAFEF00D that cycle. Without it: old value that cycle, 0xCAFEF00D the next cycle.
